// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: FU result bundles, hold-slot payload and the broadcast word.
// Also carries the ROB age helpers used to decide which results a mispredict flush kills.
package cdb_arbiter_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int PREG_W    = 7;
    localparam int DATA_W    = 32;
    localparam int NUM_FU    = 3;

    localparam logic [1:0] CDB_SRC_ALU = 2'd0;
    localparam logic [1:0] CDB_SRC_MEM = 2'd1;
    localparam logic [1:0] CDB_SRC_BR  = 2'd2;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic              fu_alu_done;
        logic              fu_alu_ready;
        logic [PREG_W-1:0] p_alu;
        logic [DATA_W-1:0] data;
        rob_tag_t          rob_fu_alu;
    } alu_data;

    typedef struct packed {
        logic              fu_mem_done;
        logic [PREG_W-1:0] p_mem;
        logic [DATA_W-1:0] data;
        rob_tag_t          rob_fu_mem;
    } mem_data;

    typedef struct packed {
        logic              fu_b_done;
        logic [PREG_W-1:0] p_b;
        logic [DATA_W-1:0] data;
        rob_tag_t          rob_fu_b;
    } b_data;

    typedef struct packed {
        logic [PREG_W-1:0] pd;
        logic [DATA_W-1:0] data;
        rob_tag_t          rob_tag;
    } slot_t;

    typedef struct packed {
        logic              valid;
        logic              prf_we;
        logic [PREG_W-1:0] pd;
        logic [DATA_W-1:0] data;
        rob_tag_t          rob_tag;
        logic [1:0]        src;
    } cdb_data;

    // Distance from the ROB head; wraps naturally in TAG_W bits.
    function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
        return tag - head;
    endfunction

    function automatic logic is_younger(input rob_tag_t tag, input rob_tag_t flush_tag,
                                        input rob_tag_t head);
        return rob_age(tag, head) > rob_age(flush_tag, head);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Three-way round-robin arbiter: combinational one-hot grant, registered rotating pointer.
// Zero-latency grant; the pointer moves to the slot after the winner only when a grant happens.
import cdb_arbiter_pkg::*;

module rr_arbiter3 (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [1:0] cand;

    function automatic logic [1:0] next3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = 2'd0;
        gnt_vld = 1'b0;
        cand    = ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
            cand = next3(cand);
        end
        ptr_nxt = gnt_vld ? next3(gnt_idx) : ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= CDB_SRC_ALU;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// One hold slot per FU feeding a round-robin pick onto the registered CDB; done->cdb valid in 2 cycles.
// A full, ungranted slot drops its ready and the FU holds; flush kills younger held or incoming results.
import cdb_arbiter_pkg::*;

module cdb_arbiter (
    input  logic     clk,
    input  logic     reset,
    input  alu_data  alu_in,
    input  mem_data  mem_in,
    input  b_data    br_in,
    output logic     alu_ready,
    output logic     mem_ready,
    output logic     br_ready,
    input  rob_tag_t rob_head,
    input  logic     flush_valid,
    input  rob_tag_t flush_tag,
    output cdb_data  cdb_out
);

    logic [NUM_FU-1:0] in_vld;
    slot_t             in_pay [NUM_FU];
    logic [NUM_FU-1:0] slot_vld;
    slot_t             slot_q [NUM_FU];
    logic [NUM_FU-1:0] kill;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] rdy;
    logic [NUM_FU-1:0] cap;
    logic [NUM_FU-1:0] gnt;
    logic [1:0]        gnt_idx;
    logic              gnt_vld;
    slot_t             sel;
    logic              unused_fu_ready;

    // The ALU's own ready flag is not consulted; acceptance is decided here.
    assign unused_fu_ready = alu_in.fu_alu_ready;

    always_comb begin
        in_vld    = {br_in.fu_b_done, mem_in.fu_mem_done, alu_in.fu_alu_done};
        in_pay[0] = '{pd: alu_in.p_alu, data: alu_in.data, rob_tag: alu_in.rob_fu_alu};
        in_pay[1] = '{pd: mem_in.p_mem, data: mem_in.data, rob_tag: mem_in.rob_fu_mem};
        in_pay[2] = '{pd: br_in.p_b,    data: br_in.data,  rob_tag: br_in.rob_fu_b};
    end

    // Wrong-path slots are masked from arbitration in the same cycle the flush arrives.
    always_comb begin
        kill = '0;
        req  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            kill[i] = flush_valid && slot_vld[i] &&
                      is_younger(slot_q[i].rob_tag, flush_tag, rob_head);
            req[i]  = slot_vld[i] && !kill[i];
        end
    end

    rr_arbiter3 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Ready ignores the flush so the FU handshake never depends on the flush path.
    always_comb begin
        rdy = '0;
        cap = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            rdy[i] = !slot_vld[i] || gnt[i];
            cap[i] = in_vld[i] && rdy[i] &&
                     !(flush_valid && is_younger(in_pay[i].rob_tag, flush_tag, rob_head));
        end
    end

    assign alu_ready = rdy[0];
    assign mem_ready = rdy[1];
    assign br_ready  = rdy[2];

    always_comb begin
        case (gnt_idx)
            2'd1:    sel = slot_q[1];
            2'd2:    sel = slot_q[2];
            default: sel = slot_q[0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_vld <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (cap[i]) begin
                    slot_vld[i] <= 1'b1;
                    slot_q[i]   <= in_pay[i];
                end else if (gnt[i] || kill[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Physical register 0 is hard-wired: the ROB still sees completion, the PRF is not written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_out <= '0;
        end else if (gnt_vld) begin
            cdb_out <= '{valid:   1'b1,
                         prf_we:  (sel.pd != '0),
                         pd:      sel.pd,
                         data:    sel.data,
                         rob_tag: sel.rob_tag,
                         src:     gnt_idx};
        end else begin
            cdb_out <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, contention, backpressure, wrapped flush, x0 and async reset.
import cdb_arbiter_pkg::*;

module tb_cdb_arbiter;

    logic     clk = 1'b0;
    logic     reset;
    alu_data  alu_in;
    mem_data  mem_in;
    b_data    br_in;
    logic     alu_ready;
    logic     mem_ready;
    logic     br_ready;
    rob_tag_t rob_head;
    logic     flush_valid;
    rob_tag_t flush_tag;
    cdb_data  cdb_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_in      (alu_in),
        .mem_in      (mem_in),
        .br_in       (br_in),
        .alu_ready   (alu_ready),
        .mem_ready   (mem_ready),
        .br_ready    (br_ready),
        .rob_head    (rob_head),
        .flush_valid (flush_valid),
        .flush_tag   (flush_tag),
        .cdb_out     (cdb_out)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic d, input logic [6:0] pd, input logic [31:0] dat,
                           input logic [4:0] t);
        alu_in = '{fu_alu_done: d, fu_alu_ready: 1'b0, p_alu: pd, data: dat, rob_fu_alu: t};
    endtask

    task automatic set_mem(input logic d, input logic [6:0] pd, input logic [31:0] dat,
                           input logic [4:0] t);
        mem_in = '{fu_mem_done: d, p_mem: pd, data: dat, rob_fu_mem: t};
    endtask

    task automatic set_br(input logic d, input logic [6:0] pd, input logic [31:0] dat,
                          input logic [4:0] t);
        br_in = '{fu_b_done: d, p_b: pd, data: dat, rob_fu_b: t};
    endtask

    task automatic clear_fus();
        set_alu(1'b0, 7'd0, 32'd0, 5'd0);
        set_mem(1'b0, 7'd0, 32'd0, 5'd0);
        set_br(1'b0, 7'd0, 32'd0, 5'd0);
    endtask

    task automatic do_reset();
        clear_fus();
        flush_valid = 1'b0;
        flush_tag   = 5'd0;
        rob_head    = 5'd0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cdb_is(input string tag, input logic we, input logic [6:0] pd,
                          input logic [31:0] dat, input logic [4:0] t, input logic [1:0] src);
        cdb_data e;
        e = '{valid: 1'b1, prf_we: we, pd: pd, data: dat, rob_tag: t, src: src};
        check(tag, 64'(cdb_out), 64'(e));
    endtask

    task automatic cdb_idle(input string tag);
        check(tag, 64'(cdb_out.valid), 64'd0);
    endtask

    initial begin
        // 1: single ALU result, reset state
        do_reset();
        #1;
        check("rst_cdb", 64'(cdb_out), 64'd0);
        check("rst_alu_rdy", 64'(alu_ready), 64'd1);
        check("rst_mem_rdy", 64'(mem_ready), 64'd1);
        check("rst_br_rdy", 64'(br_ready), 64'd1);
        step();
        set_alu(1'b1, 7'd12, 32'hDEAD_BEEF, 5'd3);
        #1;
        check("t1_alu_rdy", 64'(alu_ready), 64'd1);
        cdb_idle("t1_c1");
        step(); clear_fus(); #1;
        cdb_idle("t1_c2");
        check("t1_rdy_granted", 64'(alu_ready), 64'd1);
        step(); #1;
        cdb_is("t1_bcast", 1'b1, 7'd12, 32'hDEAD_BEEF, 5'd3, CDB_SRC_ALU);
        step(); #1;
        cdb_idle("t1_after1");
        step(); #1;
        cdb_idle("t1_after2");

        // 2: three-way contention from pointer ALU
        do_reset();
        set_alu(1'b1, 7'd1, 32'hA1, 5'd5);
        set_mem(1'b1, 7'd2, 32'hB2, 5'd6);
        set_br(1'b1, 7'd3, 32'hC3, 5'd7);
        step(); clear_fus(); #1;
        check("t2_c1_alu_rdy", 64'(alu_ready), 64'd1);
        check("t2_c1_mem_rdy", 64'(mem_ready), 64'd0);
        check("t2_c1_br_rdy", 64'(br_ready), 64'd0);
        cdb_idle("t2_c1_cdb");
        step(); #1;
        cdb_is("t2_alu", 1'b1, 7'd1, 32'hA1, 5'd5, CDB_SRC_ALU);
        check("t2_c2_alu_rdy", 64'(alu_ready), 64'd1);
        check("t2_c2_mem_rdy", 64'(mem_ready), 64'd1);
        check("t2_c2_br_rdy", 64'(br_ready), 64'd0);
        step(); #1;
        cdb_is("t2_mem", 1'b1, 7'd2, 32'hB2, 5'd6, CDB_SRC_MEM);
        check("t2_c3_br_rdy", 64'(br_ready), 64'd1);
        step(); #1;
        cdb_is("t2_br", 1'b1, 7'd3, 32'hC3, 5'd7, CDB_SRC_BR);
        step(); #1;
        cdb_idle("t2_end");

        // 3: MEM result held against a full slot
        do_reset();
        set_mem(1'b1, 7'd10, 32'h100, 5'd1);
        step();
        set_mem(1'b1, 7'd11, 32'h101, 5'd2);
        set_alu(1'b1, 7'd12, 32'hA0, 5'd3);
        set_br(1'b1, 7'd13, 32'hB0, 5'd4);
        #1;
        check("t3_c1_mem_rdy", 64'(mem_ready), 64'd1);
        step();
        clear_fus();
        set_mem(1'b1, 7'd14, 32'h102, 5'd5);
        #1;
        cdb_is("t3_mx", 1'b1, 7'd10, 32'h100, 5'd1, CDB_SRC_MEM);
        check("t3_c2_mem_rdy", 64'(mem_ready), 64'd0);
        step(); #1;
        cdb_is("t3_b0", 1'b1, 7'd13, 32'hB0, 5'd4, CDB_SRC_BR);
        check("t3_c3_mem_rdy", 64'(mem_ready), 64'd0);
        step(); #1;
        cdb_is("t3_a0", 1'b1, 7'd12, 32'hA0, 5'd3, CDB_SRC_ALU);
        check("t3_c4_mem_rdy", 64'(mem_ready), 64'd1);
        step(); clear_fus(); #1;
        cdb_is("t3_m0", 1'b1, 7'd11, 32'h101, 5'd2, CDB_SRC_MEM);
        step(); #1;
        cdb_is("t3_m1", 1'b1, 7'd14, 32'h102, 5'd5, CDB_SRC_MEM);
        step(); #1;
        cdb_idle("t3_no_dup");

        // 4: flush across the ROB wrap point
        do_reset();
        rob_head = 5'd30;
        set_alu(1'b1, 7'd4, 32'h31, 5'd31);
        set_mem(1'b1, 7'd5, 32'h02, 5'd2);
        step();
        clear_fus();
        flush_valid = 1'b1;
        flush_tag   = 5'd1;
        set_br(1'b1, 7'd6, 32'hB1, 5'd1);
        #1;
        check("t4_c1_br_rdy", 64'(br_ready), 64'd1);
        check("t4_c1_mem_rdy", 64'(mem_ready), 64'd0);
        step();
        clear_fus();
        set_alu(1'b1, 7'd7, 32'h55, 5'd5);
        #1;
        cdb_is("t4_alu31", 1'b1, 7'd4, 32'h31, 5'd31, CDB_SRC_ALU);
        check("t4_c2_mem_rdy", 64'(mem_ready), 64'd1);
        check("t4_c2_alu_rdy", 64'(alu_ready), 64'd1);
        step();
        clear_fus();
        flush_valid = 1'b0;
        #1;
        cdb_is("t4_br1", 1'b1, 7'd6, 32'hB1, 5'd1, CDB_SRC_BR);
        step(); #1;
        cdb_idle("t4_no_mem");
        step(); #1;
        cdb_idle("t4_no_young_alu");

        // 5: destination x0 completes without PRF write
        do_reset();
        set_alu(1'b1, 7'd0, 32'h0000_0055, 5'd4);
        step(); clear_fus();
        step(); #1;
        cdb_is("t5_x0", 1'b0, 7'd0, 32'h0000_0055, 5'd4, CDB_SRC_ALU);

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        set_alu(1'b1, 7'd21, 32'h21, 5'd8);
        set_mem(1'b1, 7'd22, 32'h22, 5'd9);
        set_br(1'b1, 7'd23, 32'h23, 5'd10);
        step(); clear_fus();
        step(); #1;
        cdb_is("t6_pre", 1'b1, 7'd21, 32'h21, 5'd8, CDB_SRC_ALU);
        #1;
        reset = 1'b1;
        #1;
        check("t6_cdb_vld", 64'(cdb_out.valid), 64'd0);
        check("t6_alu_rdy", 64'(alu_ready), 64'd1);
        check("t6_mem_rdy", 64'(mem_ready), 64'd1);
        check("t6_br_rdy", 64'(br_ready), 64'd1);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            cdb_idle($sformatf("t6_quiet%0d", i));
        end
        set_mem(1'b1, 7'd24, 32'h24, 5'd11);
        step(); clear_fus();
        step(); #1;
        cdb_is("t6_recover", 1'b1, 7'd24, 32'h24, 5'd11, CDB_SRC_MEM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
